// File: rtl/decoder_strobe.sv
// Registered binary-to-one-hot decoder with valid/ready input, level or
// fixed-length pulse output, and a one-cycle flag for out-of-range codes.
module decoder_strobe #(
  parameter int IN_WIDTH    = 4,
  parameter int NUM_OUTPUTS = 16,
  parameter int PULSE_LEN   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_WIDTH-1:0]    binary_in,
  output logic [NUM_OUTPUTS-1:0] decoder_out,
  output logic                   busy,
  output logic                   code_err
);

  localparam int CW = $clog2(PULSE_LEN + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_PULSE = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_OUTPUTS-1:0] out_q, out_d;
  logic                   err_q, err_d;
  logic [NUM_OUTPUTS-1:0] onehot;
  logic                   accept, in_range;

  for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_lane
    assign onehot[i] = (binary_in == IN_WIDTH'(i));
  end

  // Last pulse cycle may accept, giving gapless back-to-back strobes.
  assign in_ready = enable & ((state_q != S_PULSE) | (cnt_q == CW'(1)));
  assign accept   = enable & in_valid & in_ready;
  assign in_range = (32'(binary_in) < NUM_OUTPUTS);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    err_d   = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      out_d   = '0;
    end else if (accept) begin
      if (in_range) begin
        out_d = onehot;
        if (mode) begin
          state_d = S_PULSE;
          cnt_d   = CW'(PULSE_LEN);
        end else begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      end else begin
        state_d = S_IDLE;
        cnt_d   = '0;
        out_d   = '0;
        err_d   = 1'b1;
      end
    end else if (state_q == S_PULSE) begin
      if (cnt_q == CW'(1)) begin
        state_d = S_IDLE;
        cnt_d   = '0;
        out_d   = '0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign decoder_out = out_q;
  assign busy        = (state_q == S_PULSE);
  assign code_err    = err_q;

endmodule

// File: tb/tb_decoder_strobe.sv
// Directed bench for decoder_strobe: two instances (16 outputs / 3-cycle
// pulse, and 10 outputs / 5-cycle pulse) checked through an expectation queue.
module tb_decoder_strobe;

  logic clk, rst_n;

  logic        a_en, a_mode, a_vld, a_rdy, a_busy, a_err;
  logic [3:0]  a_code;
  logic [15:0] a_dout;

  logic        b_en, b_mode, b_vld, b_rdy, b_busy, b_err;
  logic [3:0]  b_code;
  logic [9:0]  b_dout;

  decoder_strobe #(.IN_WIDTH(4), .NUM_OUTPUTS(16), .PULSE_LEN(3)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(a_en), .mode(a_mode), .in_valid(a_vld),
    .in_ready(a_rdy), .binary_in(a_code), .decoder_out(a_dout), .busy(a_busy),
    .code_err(a_err));

  decoder_strobe #(.IN_WIDTH(4), .NUM_OUTPUTS(10), .PULSE_LEN(5)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(b_en), .mode(b_mode), .in_valid(b_vld),
    .in_ready(b_rdy), .binary_in(b_code), .decoder_out(b_dout), .busy(b_busy),
    .code_err(b_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dout;
    logic        busy;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;
  int   step   = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s step %0d: observed %h expected %h", tag, step, obs, exp);
  endtask

  // One clock cycle on instance sel (0=A, 1=B): drive, check in_ready,
  // queue post-edge expectations, then pop and compare after the edge.
  task automatic cyc(input int sel, input logic en, input logic v,
                     input logic [3:0] code, input logic m, input logic exp_rdy,
                     input logic [15:0] eo, input logic eb, input logic ee);
    exp_t e;
    step++;
    if (sel == 0) begin
      a_en = en; a_vld = v; a_code = code; a_mode = m;
    end else begin
      b_en = en; b_vld = v; b_code = code; b_mode = m;
    end
    #1;
    chk("in_ready", {15'd0, (sel == 0) ? a_rdy : b_rdy}, {15'd0, exp_rdy});
    exp_q.push_back('{dout: eo, busy: eb, err: ee});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("decoder_out", (sel == 0) ? a_dout : {6'd0, b_dout}, e.dout);
    chk("busy", {15'd0, (sel == 0) ? a_busy : b_busy}, {15'd0, e.busy});
    chk("code_err", {15'd0, (sel == 0) ? a_err : b_err}, {15'd0, e.err});
  endtask

  initial begin
    rst_n = 1'b0;
    a_en = 1'b1; a_vld = 1'b0; a_code = '0; a_mode = 1'b0;
    b_en = 1'b1; b_vld = 1'b0; b_code = '0; b_mode = 1'b0;
    #12;
    chk("rst_dout_a", a_dout, 16'h0);
    chk("rst_busy_a", {15'd0, a_busy}, 16'h0);
    chk("rst_dout_b", {6'd0, b_dout}, 16'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Level sweep, one accept per cycle
    for (int i = 0; i < 16; i++)
      cyc(0, 1, 1, 4'(i), 0, 1, 16'h1 << i, 0, 0);
    cyc(0, 1, 1, 4'hA, 0, 1, 16'h0400, 0, 0);
    for (int i = 0; i < 10; i++)
      cyc(0, 1, 0, 4'h0, 1, 1, 16'h0400, 0, 0);

    // Single 3-cycle pulse on code 5
    cyc(0, 1, 1, 4'h5, 1, 1, 16'h0020, 1, 0);
    cyc(0, 1, 0, 4'h0, 0, 0, 16'h0020, 1, 0);
    cyc(0, 1, 0, 4'h0, 0, 0, 16'h0020, 1, 0);
    cyc(0, 1, 0, 4'h0, 0, 1, 16'h0000, 0, 0);

    // Gapless pulses: code 2 then code 7 in the last pulse cycle
    cyc(0, 1, 1, 4'h2, 1, 1, 16'h0004, 1, 0);
    cyc(0, 1, 1, 4'h9, 1, 0, 16'h0004, 1, 0);
    cyc(0, 1, 1, 4'h9, 1, 0, 16'h0004, 1, 0);
    cyc(0, 1, 1, 4'h7, 1, 1, 16'h0080, 1, 0);
    cyc(0, 1, 0, 4'h0, 1, 0, 16'h0080, 1, 0);
    cyc(0, 1, 0, 4'h0, 1, 0, 16'h0080, 1, 0);
    cyc(0, 1, 0, 4'h0, 1, 1, 16'h0000, 0, 0);

    // Asynchronous reset mid-pulse
    cyc(0, 1, 1, 4'h1, 1, 1, 16'h0002, 1, 0);
    cyc(0, 1, 0, 4'h0, 1, 0, 16'h0002, 1, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_dout", a_dout, 16'h0);
    chk("rst_mid_busy", {15'd0, a_busy}, 16'h0);
    chk("rst_mid_err", {15'd0, a_err}, 16'h0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("rst_rel_ready", {15'd0, a_rdy}, 16'h1);
    @(posedge clk);
    #1;
    chk("rst_rel_idle", a_dout, 16'h0);

    // Out-of-range with 10 outputs
    cyc(1, 1, 1, 4'd12, 0, 1, 16'h0000, 0, 1);
    cyc(1, 1, 0, 4'd0,  0, 1, 16'h0000, 0, 0);
    cyc(1, 1, 1, 4'd9,  0, 1, 16'h0200, 0, 0);
    cyc(1, 1, 0, 4'd0,  0, 1, 16'h0200, 0, 0);
    cyc(1, 1, 1, 4'd15, 1, 1, 16'h0000, 0, 1);
    cyc(1, 1, 1, 4'd10, 0, 1, 16'h0000, 0, 1);
    cyc(1, 1, 0, 4'd0,  0, 1, 16'h0000, 0, 0);

    // Enable drop in pulse cycle 2, then re-enable with a full 5-cycle pulse
    cyc(1, 1, 1, 4'd3, 1, 1, 16'h0008, 1, 0);
    cyc(1, 0, 0, 4'd0, 1, 0, 16'h0000, 0, 0);
    cyc(1, 0, 1, 4'd4, 1, 0, 16'h0000, 0, 0);
    cyc(1, 1, 1, 4'd4, 1, 1, 16'h0010, 1, 0);
    for (int i = 0; i < 4; i++)
      cyc(1, 1, 0, 4'd0, 0, 0, 16'h0010, 1, 0);
    cyc(1, 1, 0, 4'd0, 0, 1, 16'h0000, 0, 0);

    chk("queue_drained", 16'(exp_q.size()), 16'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
